// File: rtl/z80_io_hub.sv
`timescale 1ns/1ps
// z80_io_hub: Z80 I/O hub with control register, glitch-free CPU clock
// divider, HD44780-style LCD write sequencer and status/keyboard decode.
//
// Ports:
//   in_clock            single clock, all flops on its rising edge
//   rst                 synchronous active-low reset
//   adr, data_i         Z80 low address bits / data bus in
//   data_o, data_oe     status read data and bus drive enable (combinational)
//   iorq, rd, wr, m1    Z80 strobes, active-low
//   cpu_clock           divided Z80 clock (fast/slow, switched at counter zero)
//   wait_n              Z80 WAIT (combinational)
//   led, lcd_rw, lcd_rs control register bits 0, 1, 2
//   gpio_o              control register bits 7:4
//   lcd_e, lcd_d        LCD enable strobe and latched LCD data
//   kbd_n               keyboard enable, active-low (combinational)
//
// Build option: define Z80KAA_LCD_WAIT_EN to stall LCD-port writes with
// wait_n while a transfer is in progress instead of dropping them.
module z80_io_hub #(
  parameter int unsigned        ADDR_W    = 3,
  parameter logic [ADDR_W-1:0]  PORT_CTRL = ADDR_W'(3'b110),
  parameter logic [ADDR_W-1:0]  PORT_LCD  = ADDR_W'(3'b101),
  parameter logic [ADDR_W-1:0]  PORT_STAT = ADDR_W'(3'b100),
  parameter int unsigned        SETUP_CYC = 2,
  parameter int unsigned        E_CYC     = 12,
  parameter int unsigned        HOLD_CYC  = 2,
  parameter int unsigned        FAST_BIT  = 1,
  parameter int unsigned        SLOW_BIT  = 4
) (
  input  logic              in_clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  output logic              data_oe,
  input  logic              iorq,
  input  logic              rd,
  input  logic              wr,
  input  logic              m1,
  output logic              cpu_clock,
  output logic              wait_n,
  output logic              led,
  output logic              lcd_rw,
  output logic              lcd_rs,
  output logic [3:0]        gpio_o,
  output logic              lcd_e,
  output logic [7:0]        lcd_d,
  output logic              kbd_n
);

  localparam int unsigned CNT_W   = SLOW_BIT + 1;
  localparam int unsigned MAX_A   = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} lcd_state_e;

  lcd_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic iorq_s1_q, iorq_s2_q, rd_s1_q, rd_s2_q, wr_s1_q, wr_s2_q;
  logic [1:0] vld_q;
  logic wr_act_q, wr_act_d, rd_prev_q, stat_sel_q, stat_sel_d;
  logic [7:0] ctrl_q, lcd_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d, cpu_clk_q, cpu_clk_d;
  logic ovr_q, ovr_d, lcd_e_q, lcd_e_d;

  logic wr_act, sync_vld, stall, wstb, lcd_hit, ctrl_hit, busy;
  logic lcd_ld, ovr_set, ovr_clr, io_rd;
  logic [7:0] status;

  // Write strobe: rising edge of synchronized (iorq & wr) low, qualified by m1.
  // The sync pipe holds stale reset values for two cycles after reset release,
  // so the edge detector is frozen "active" until the pipe has refilled.
  assign wr_act   = ~iorq_s2_q & ~wr_s2_q;
  assign sync_vld = vld_q[1];
  assign busy     = (state_q != S_IDLE);

`ifdef Z80KAA_LCD_WAIT_EN
  // A stalled LCD write is not seen as active until the FSM is idle again.
  assign stall  = busy & (adr == PORT_LCD);
  assign wait_n = ~(busy & ~iorq & (adr == PORT_LCD));
`else
  assign stall  = 1'b0;
  assign wait_n = 1'b1;
`endif

  assign wstb     = sync_vld & wr_act & ~wr_act_q & m1 & ~stall;
  assign wr_act_d = ~sync_vld ? 1'b1 : (stall ? (wr_act_q & wr_act) : wr_act);
  assign lcd_hit  = wstb & (adr == PORT_LCD);
  assign ctrl_hit = wstb & (adr == PORT_CTRL);

  // Overrun clears on the trailing edge of a synchronized status read.
  assign stat_sel_d = ~iorq_s2_q & ~rd_s2_q & m1 & (adr == PORT_STAT);
  assign ovr_clr    = rd_s2_q & ~rd_prev_q & stat_sel_q;
  assign ovr_d      = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

  // Clock selection only changes at counter zero, where both taps are low.
  assign sel_d     = (cnt_q == '0) ? ctrl_q[3] : sel_q;
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign cpu_clk_d = sel_d ? cnt_d[SLOW_BIT] : cnt_d[FAST_BIT];

  // Raw-pin read decode for status and keyboard enable.
  assign io_rd   = ~iorq & ~rd & m1;
  assign status  = {ovr_q, busy, 5'b0, sel_q};
  assign data_oe = io_rd & (adr == PORT_STAT);
  assign data_o  = data_oe ? status : 8'h00;
  assign kbd_n   = ~(io_rd & (adr == PORT_CTRL));

  // LCD FSM state register.
  always_ff @(posedge in_clock) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // LCD FSM next state: each phase counts its cycle budget down to zero.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (lcd_hit) begin
          state_d = S_SETUP;
          tmr_d   = TMR_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_PULSE;
          tmr_d   = TMR_W'(E_CYC - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          state_d = S_HOLD;
          tmr_d   = TMR_W'(HOLD_CYC - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // LCD FSM outputs: accept/drop decision and next lcd_e.
  always_comb begin
    lcd_ld  = lcd_hit & ~busy;
    ovr_set = lcd_hit & busy;
    lcd_e_d = (state_d == S_PULSE);
  end

  // Synchronizers, control register, divider, LCD data and flags.
  always_ff @(posedge in_clock) begin
    if (!rst) begin
      iorq_s1_q  <= 1'b1;
      iorq_s2_q  <= 1'b1;
      rd_s1_q    <= 1'b1;
      rd_s2_q    <= 1'b1;
      wr_s1_q    <= 1'b1;
      wr_s2_q    <= 1'b1;
      vld_q      <= 2'b00;
      wr_act_q   <= 1'b1;
      rd_prev_q  <= 1'b1;
      stat_sel_q <= 1'b0;
      ctrl_q     <= 8'h00;
      lcd_d_q    <= 8'h00;
      lcd_e_q    <= 1'b0;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      cpu_clk_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      iorq_s1_q  <= iorq;
      iorq_s2_q  <= iorq_s1_q;
      rd_s1_q    <= rd;
      rd_s2_q    <= rd_s1_q;
      wr_s1_q    <= wr;
      wr_s2_q    <= wr_s1_q;
      vld_q      <= {vld_q[0], 1'b1};
      wr_act_q   <= wr_act_d;
      rd_prev_q  <= rd_s2_q;
      stat_sel_q <= stat_sel_d;
      if (ctrl_hit) ctrl_q <= data_i;
      if (lcd_ld) lcd_d_q <= data_i;
      lcd_e_q    <= lcd_e_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      cpu_clk_q  <= cpu_clk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign led       = ctrl_q[0];
  assign lcd_rw    = ctrl_q[1];
  assign lcd_rs    = ctrl_q[2];
  assign gpio_o    = ctrl_q[7:4];
  assign lcd_e     = lcd_e_q;
  assign lcd_d     = lcd_d_q;
  assign cpu_clock = cpu_clk_q;

endmodule

// File: tb/tb_z80_io_hub.sv
`timescale 1ns/1ps
// Self-checking bench for z80_io_hub: directed scenarios plus a randomized
// phase, all checked every cycle against a transaction-level reference model.
module tb_z80_io_hub;

  localparam logic [2:0] A_CTRL = 3'b110;
  localparam logic [2:0] A_LCD  = 3'b101;
  localparam logic [2:0] A_STAT = 3'b100;
`ifdef Z80KAA_LCD_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       in_clock = 1'b0;
  logic       rst, iorq, rd, wr, m1;
  logic [2:0] adr;
  logic [7:0] data_i, data_o, lcd_d;
  logic       data_oe, cpu_clock, wait_n, led, lcd_rw, lcd_rs, lcd_e, kbd_n;
  logic [3:0] gpio_o;

  z80_io_hub dut (
    .in_clock(in_clock), .rst(rst), .adr(adr), .data_i(data_i),
    .data_o(data_o), .data_oe(data_oe), .iorq(iorq), .rd(rd), .wr(wr),
    .m1(m1), .cpu_clock(cpu_clock), .wait_n(wait_n), .led(led),
    .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .gpio_o(gpio_o), .lcd_e(lcd_e),
    .lcd_d(lcd_d), .kbd_n(kbd_n)
  );

  always #5 in_clock = ~in_clock;

  int checks = 0;
  int errors = 0;

  // Reference model: transfer age m_k counts cycles since an accepted LCD
  // write (0..15 busy: 2 setup, 12 pulse, 2 hold); m_cnt is the divider count.
  int         m_cnt, m_k, pw_cnt, clr_cnt;
  logic       m_sel, m_ovr;
  logic [7:0] m_ctrl, m_lcd_d, pw_data;
  logic [2:0] pw_adr;
  bit         pw_valid;
  int         e_hi, wait_low;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return m_k < 16;
  endfunction

  task automatic model_edge();
    bit busy_pre, set, clr;
    logic [7:0] ctrl_pre;
    if (!rst) begin
      m_ctrl = 8'h00; m_lcd_d = 8'h00; m_k = 16; m_cnt = 0;
      m_sel = 1'b0; m_ovr = 1'b0; pw_valid = 1'b0; clr_cnt = 0;
    end else begin
      busy_pre = m_busy();
      ctrl_pre = m_ctrl;
      set = 1'b0; clr = 1'b0;
      if (m_cnt == 0) m_sel = ctrl_pre[3];
      m_cnt = (m_cnt + 1) % 32;
      if (m_k < 16) m_k++;
      if (clr_cnt > 0) begin
        clr_cnt--;
        if (clr_cnt == 0) clr = 1'b1;
      end
      if (pw_valid) begin
        if (pw_cnt > 1) pw_cnt--;
        else if (WAIT_EN && pw_adr == A_LCD && busy_pre) begin
          // CPU is stalled; the write lands once the transfer finishes
        end else begin
          pw_valid = 1'b0;
          if (pw_adr == A_CTRL) m_ctrl = pw_data;
          else if (pw_adr == A_LCD) begin
            if (busy_pre) set = 1'b1;
            else begin m_lcd_d = pw_data; m_k = 0; end
          end
        end
      end
      if (clr) m_ovr = 1'b0;
      if (set) m_ovr = 1'b1;
    end
  endtask

  task automatic check_all();
    bit rdsel, oe;
    int cpu;
    logic [7:0] st;
    rdsel = !iorq && !rd && m1;
    oe    = rdsel && (adr == A_STAT);
    st    = {m_ovr, m_busy(), 5'b0, m_sel};
    cpu   = m_sel ? ((m_cnt / 16) % 2) : ((m_cnt / 2) % 2);
    chk("led", 8'(led), 8'(m_ctrl[0]));
    chk("lcd_rw", 8'(lcd_rw), 8'(m_ctrl[1]));
    chk("lcd_rs", 8'(lcd_rs), 8'(m_ctrl[2]));
    chk("gpio_o", 8'(gpio_o), 8'(m_ctrl[7:4]));
    chk("lcd_d", lcd_d, m_lcd_d);
    chk("lcd_e", 8'(lcd_e), 8'(m_k >= 2 && m_k < 14));
    chk("cpu_clock", 8'(cpu_clock), 8'(cpu));
    chk("data_oe", 8'(data_oe), 8'(oe));
    chk("data_o", data_o, oe ? st : 8'h00);
    chk("kbd_n", 8'(kbd_n), 8'(!(rdsel && adr == A_CTRL)));
    chk("wait_n", 8'(wait_n),
        8'(WAIT_EN ? !(m_busy() && !iorq && adr == A_LCD) : 1'b1));
  endtask

  task automatic tick();
    @(posedge in_clock);
    model_edge();
    #1;
    if (lcd_e === 1'b1) e_hi++;
    if (wait_n === 1'b0) wait_low++;
    check_all();
  endtask

  task automatic io_write(input logic [2:0] a, input logic [7:0] d, input logic m);
    int n;
    adr = a; data_i = d; m1 = m; iorq = 1'b0; wr = 1'b0;
    if (m) begin
      pw_valid = 1'b1; pw_cnt = 3; pw_adr = a; pw_data = d;
      n = 0;
      while (pw_valid && n < 64) begin tick(); n++; end
      chk("write_done", 8'(pw_valid), 8'h00);
      pw_valid = 1'b0;
    end else begin
      repeat (3) tick();
    end
    iorq = 1'b1; wr = 1'b1;
    repeat (3) tick();
    m1 = 1'b1;
  endtask

  task automatic io_read(input logic [2:0] a, input logic m,
                         output logic [7:0] st, output logic oe, output logic kb);
    adr = a; m1 = m; iorq = 1'b0; rd = 1'b0;
    repeat (3) tick();
    st = data_o; oe = data_oe; kb = kbd_n;
    iorq = 1'b1; rd = 1'b1;
    if (m && a == A_STAT) clr_cnt = 3;
    repeat (3) tick();
    m1 = 1'b1;
  endtask

  initial begin
    logic [7:0] st, d;
    logic oe, kb, prev;
    int t_first, t_second, n, op;

    rst = 1'b0; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1;
    adr = 3'b000; data_i = 8'h00;
    m_k = 16; m_cnt = 0; m_sel = 1'b0; m_ovr = 1'b0; m_ctrl = 8'h00;
    m_lcd_d = 8'h00; pw_valid = 1'b0; pw_cnt = 0; clr_cnt = 0;
    pw_adr = 3'b000; pw_data = 8'h00; e_hi = 0; wait_low = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_wait_n", 8'(wait_n), 8'h01);
    chk("rst_cpu_clock", 8'(cpu_clock), 8'h00);
    rst = 1'b1;
    repeat (4) tick();

    // Control write 0x0D, then slow clock period
    io_write(A_CTRL, 8'h0D, 1'b1);
    chk("ctrl_led", 8'(led), 8'h01);
    chk("ctrl_rw", 8'(lcd_rw), 8'h00);
    chk("ctrl_rs", 8'(lcd_rs), 8'h01);
    chk("ctrl_gpio", 8'(gpio_o), 8'h00);
    n = 0;
    while (!m_sel && n < 40) begin tick(); n++; end
    t_first = -1; t_second = -1; prev = cpu_clock;
    for (int i = 0; i < 100 && t_second < 0; i++) begin
      tick();
      if (cpu_clock && !prev) begin
        if (t_first < 0) t_first = i; else t_second = i;
      end
      prev = cpu_clock;
    end
    chk("slow_period", 8'(t_second - t_first), 8'd32);
    io_write(A_CTRL, 8'h00, 1'b1);
    repeat (40) tick();

    // Single LCD transfer
    e_hi = 0;
    io_write(A_LCD, 8'h41, 1'b1);
    chk("lcd_latch", lcd_d, 8'h41);
    repeat (20) tick();
    chk("e_width", 8'(e_hi), 8'd12);
    io_read(A_STAT, 1'b1, st, oe, kb);
    chk("stat_idle_busy", 8'(st[6]), 8'h00);

    // Overlapping LCD writes
    wait_low = 0;
    io_write(A_LCD, 8'h41, 1'b1);
    io_write(A_LCD, 8'h42, 1'b1);
    if (WAIT_EN) begin
      chk("stall_lcd_d", lcd_d, 8'h42);
      chk("stall_wait_seen", 8'(wait_low > 0), 8'h01);
    end else begin
      chk("drop_lcd_d", lcd_d, 8'h41);
      chk("nowait_seen", 8'(wait_low), 8'h00);
    end
    io_read(A_STAT, 1'b1, st, oe, kb);
    chk("stat_busy", 8'(st[6]), 8'h01);
    chk("stat_ovr1", 8'(st[7]), WAIT_EN ? 8'h00 : 8'h01);
    io_read(A_STAT, 1'b1, st, oe, kb);
    chk("stat_ovr2", 8'(st[7]), 8'h00);
    repeat (24) tick();

    // Keyboard read, interrupt-acknowledge reads/writes
    io_read(A_CTRL, 1'b1, st, oe, kb);
    chk("kbd_read_kbd", 8'(kb), 8'h00);
    chk("kbd_read_oe", 8'(oe), 8'h00);
    io_read(A_STAT, 1'b0, st, oe, kb);
    chk("m1_stat_oe", 8'(oe), 8'h00);
    chk("m1_stat_do", st, 8'h00);
    io_write(A_CTRL, 8'hFF, 1'b0);
    chk("m1_write_gpio", 8'(gpio_o), 8'h00);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 6));
      d  = 8'($urandom);
      case (op)
        0: io_write(A_CTRL, d, 1'b1);
        1, 2: io_write(A_LCD, d, 1'b1);
        3: io_read(A_STAT, 1'b1, st, oe, kb);
        4: io_read(A_CTRL, 1'b1, st, oe, kb);
        5: io_write(A_CTRL, d, 1'b0);
        default: repeat (int'($urandom_range(1, 20))) tick();
      endcase
    end
    repeat (24) tick();

    // Reset in the 5th PULSE cycle with iorq/wr held low across release
    io_write(A_CTRL, 8'hA5, 1'b1);
    io_write(A_LCD, 8'h5A, 1'b1);
    n = 0;
    while (m_k != 6 && n < 40) begin tick(); n++; end
    chk("pulse_reached", 8'(lcd_e), 8'h01);
    rst = 1'b0; adr = A_CTRL; data_i = 8'hFF; iorq = 1'b0; wr = 1'b0;
    tick();
    chk("rstp_lcd_e", 8'(lcd_e), 8'h00);
    chk("rstp_led", 8'(led), 8'h00);
    chk("rstp_cpu", 8'(cpu_clock), 8'h00);
    chk("rstp_lcd_d", lcd_d, 8'h00);
    rst = 1'b1;
    repeat (6) tick();
    chk("no_spurious_gpio", 8'(gpio_o), 8'h00);
    iorq = 1'b1; wr = 1'b1;
    repeat (4) tick();
    io_read(A_STAT, 1'b1, st, oe, kb);
    chk("post_rst_stat", st, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_io_hub.md
Z80_IO_HUB -- requirements
Module: z80_io_hub

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 3, decoded I/O address bits.
- PORT_CTRL, 3'b110, control register write port; a read of this port also enables the keyboard.
- PORT_LCD, 3'b101, LCD data write port.
- PORT_STAT, 3'b100, status read port.
- SETUP_CYC, 2, in_clock cycles of RS/RW setup before E.
- E_CYC, 12, in_clock cycles lcd_e is high.
- HOLD_CYC, 2, in_clock cycles after E falls.
- FAST_BIT, 1, divider bit used for the fast cpu_clock.
- SLOW_BIT, 4, divider bit used for the slow cpu_clock (must be greater than FAST_BIT).

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- in_clock, in, 1, single clock, all logic on its rising edge.
- rst, in, 1, synchronous active-low reset.
- adr, in, ADDR_W, Z80 low address bits.
- data_i, in, 8, Z80 data bus input.
- data_o, out, 8, read data.
- data_oe, out, 1, bus drive enable.
- iorq / rd / wr / m1, in, 1 each, Z80 strobes, active-low.
- cpu_clock, out, 1, divided Z80 clock.
- wait_n, out, 1, Z80 WAIT.
- led, out, 1, ctrl[0].
- lcd_rw, out, 1, ctrl[1].
- lcd_rs, out, 1, ctrl[2].
- gpio_o, out, 4, ctrl[7:4].
- lcd_e, out, 1, LCD enable strobe.
- lcd_d, out, 8, latched LCD data.
- kbd_n, out, 1, keyboard enable, active-low.

REQ-003 The block SHALL use one clock (in_clock), and reset SHALL be synchronous and active-low (rst).

Function
REQ-004 iorq, rd and wr SHALL each pass through a 2-flop synchronizer.
REQ-005 A write strobe (wstb) SHALL be one cycle long, asserted on the first cycle the synchronized iorq and wr are both low after either was high, and only when m1 is high.
REQ-006 data_i and adr SHALL be sampled in the wstb cycle.
REQ-007 On wstb with adr==PORT_CTRL, ctrl SHALL load data_i, visible on the outputs the following cycle.
REQ-008 ctrl[3] SHALL select the clock speed: 0 = fast, 1 = slow.
REQ-009 A free-running counter of SLOW_BIT+1 bits SHALL wrap to zero.
REQ-010 cpu_clock SHALL equal cnt[FAST_BIT] or cnt[SLOW_BIT] according to the active selection.
REQ-011 The active selection SHALL copy ctrl[3] only in the cycle the counter equals zero, so cpu_clock never produces a runt pulse.
REQ-012 The LCD FSM SHALL have the states IDLE, SETUP, PULSE and HOLD.
REQ-013 In IDLE, on wstb with adr==PORT_LCD, the FSM SHALL latch lcd_d from data_i and go to SETUP.
REQ-014 SETUP SHALL last SETUP_CYC cycles, PULSE E_CYC cycles with lcd_e=1, and HOLD HOLD_CYC cycles, then the FSM SHALL return to IDLE.
REQ-015 lcd_e SHALL be registered and be high only in PULSE.
REQ-016 busy SHALL be asserted whenever the FSM state is not IDLE.
REQ-017 An LCD-port wstb while busy SHALL be dropped: lcd_d is unchanged and the sticky overrun flag is set.
REQ-018 If a write to PORT_CTRL occurs during a transfer, lcd_rs and lcd_rw SHALL change immediately; software is responsible for avoiding this.
REQ-019 The status byte SHALL be {overrun, busy, 5'b0, active clock selection}.
REQ-020 While raw iorq=0, rd=0, m1=1 and adr==PORT_STAT, data_oe SHALL be 1 and data_o SHALL be the status byte, both combinational from the raw pins.
REQ-021 Otherwise data_oe SHALL be 0 and data_o SHALL be 0.
REQ-022 overrun SHALL clear on the first cycle the synchronized status read ends (rising edge of synchronized rd while the decode matched).
REQ-023 If a set and a clear of overrun happen in the same cycle, the set SHALL win.
REQ-024 kbd_n SHALL be 0, combinationally, while raw iorq=0, rd=0, m1=1 and adr==PORT_CTRL; otherwise kbd_n SHALL be 1.
REQ-025 While m1=0 (interrupt acknowledge), the block SHALL produce no write strobe, no data_oe and no kbd_n.

Reset
REQ-026 While rst=0 at a clock edge, the following SHALL be cleared: ctrl=0, lcd_d=0, lcd_e=0, FSM=IDLE, counter=0, selection=fast, overrun=0, and synchronizer flops=1 (inactive).
REQ-027 Reset outputs SHALL be led=lcd_rw=lcd_rs=0, gpio_o=0, cpu_clock=0 and wait_n=1.
REQ-028 A reset during PULSE SHALL drop lcd_e on the next edge and abort the transfer.
REQ-029 No spurious wstb SHALL occur on reset release while iorq/wr are held low.

Configuration
REQ-030 With Z80KAA_LCD_WAIT_EN defined, wait_n SHALL be 0 while busy and raw iorq=0 and adr==PORT_LCD, stalling the CPU until the FSM reaches IDLE, so overrun cannot occur on a stalled write.
REQ-031 With Z80KAA_LCD_WAIT_EN undefined, wait_n SHALL be constant 1 and the overrun detection of REQ-017 still applies.

Verification
REQ-032 Write 0x0D to PORT_CTRL -> led=1, lcd_rw=0, lcd_rs=1, gpio_o=0; the selection switches to slow only at the next counter zero and cpu_clock then has period 32 in_clock cycles.
REQ-033 Write 0x41 to PORT_LCD -> lcd_d=0x41; lcd_e rises after 2 cycles of SETUP, stays high exactly 12 cycles, then 2 cycles of HOLD; the status read gives bit6=1 during the transfer and 0 afterwards.
REQ-034 Second LCD write (0x42) 4 cycles after the first, macro undefined -> lcd_d stays 0x41; a status read returns bit7=1; a following status read returns bit7=0.
REQ-035 Same stimulus as REQ-034 with the macro defined -> wait_n stays low until IDLE, and no overrun is recorded.
REQ-036 Read of PORT_CTRL -> kbd_n=0 and data_oe=0; read of PORT_STAT with m1=0 -> data_oe=0.
REQ-037 rst=0 asserted in the 5th cycle of PULSE -> lcd_e=0 next edge, FSM=IDLE, ctrl=0, cpu_clock=0.
